reorder_buffer_mc: RTL and testbench

Parametrised in-order-commit reorder buffer for the out-of-order MIPS core; successor to the single-channel 32-entry ROB.
- Allocates a tag per dispatched instruction (tail).
- Accepts results out of order on NUM_WB parallel writeback channels.
- Retires strictly in program order (head) through a valid/ready commit handshake, with full/empty/count status and a flush for mispredict recovery.

---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_ptr.sv | 34 +++
 rtl/reorder_buffer_mc.sv | 137 +++++++++++++
 tb/tb_reorder_buffer_mc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the multi-channel reorder buffer.
// Contents:
//   DEF_*         default sizing constants used by the top-level parameters
//   rob_flags_t   per-entry control state (valid, done)
//   alloc_rec_t   dispatch-side record at default widths
//   commit_rec_t  retire-side record at default widths
package rob_pkg;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_WB = 2;

  typedef struct packed {
    logic valid;
    logic done;
  } rob_flags_t;

  typedef struct packed {
    logic [DEF_REG_W-1:0] reg_idx;
  } alloc_rec_t;

  typedef struct packed {
    logic [DEF_REG_W-1:0]  reg_idx;
    logic [DEF_DATA_W-1:0] data;
  } commit_rec_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around pointer used for the ROB head and tail.
// Ports:
//   clk_i  rising-edge clock
//   clr_i  synchronous clear to zero (takes priority over inc_i)
//   inc_i  advance by one, wrapping 2**W-1 -> 0
//   ptr_o  current pointer value
module rob_ptr
  import rob_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Natural W-bit overflow gives the wrap because the ROB depth is a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order-commit reorder buffer with NUM_WB parallel writeback channels.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   alloc_valid/ready/reg/tag  dispatch: allocate an entry at the tail
//   wb_valid/tag/data          packed per-channel writebacks (channel i at [i*W +: W])
//   commit_valid/ready/reg/data/tag  retire the head entry once it is done
//   flush                      discard every entry (mispredict recovery)
//   count, empty, full         occupancy status
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int REG_W  = DEF_REG_W,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NUM_WB = DEF_NUM_WB,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [REG_W-1:0]         alloc_reg,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [REG_W-1:0]         commit_reg,
  output logic [DATA_W-1:0]        commit_data,
  output logic [TAG_W-1:0]         commit_tag,
  input  logic                     flush,
  output logic [TAG_W:0]           count,
  output logic                     empty,
  output logic                     full
);

  rob_flags_t        flags_q [DEPTH];
  rob_flags_t        flags_d [DEPTH];
  logic [REG_W-1:0]  reg_q   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [TAG_W:0]    count_q;
  logic [TAG_W:0]    count_d;
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;

  logic [TAG_W-1:0]  wb_tag_a  [NUM_WB];
  logic [DATA_W-1:0] wb_data_a [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;

  logic clr;
  logic alloc_fire;
  logic commit_fire;

  assign clr = reset | flush;

  // Unpack channel buses and qualify each strobe against the target's valid bit.
  always_comb begin
    for (int i = 0; i < NUM_WB; i++) begin
      wb_tag_a[i]  = wb_tag[i*TAG_W +: TAG_W];
      wb_data_a[i] = wb_data[i*DATA_W +: DATA_W];
      wb_hit[i]    = wb_valid[i] & flags_q[wb_tag[i*TAG_W +: TAG_W]].valid;
    end
  end

  // Allocation sees only the full flag: no same-cycle commit bypass.
  assign full        = (count_q == (TAG_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = ~full;
  assign alloc_fire  = alloc_valid & ~full;

  assign commit_valid = flags_q[head].valid & flags_q[head].done;
  assign commit_fire  = commit_valid & commit_ready;
  assign commit_reg   = reg_q[head];
  assign commit_data  = data_q[head];
  assign commit_tag   = head;
  assign alloc_tag    = tail;
  assign count        = count_q;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk_i (clk),
    .clr_i (clr),
    .inc_i (commit_fire),
    .ptr_o (head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk_i (clk),
    .clr_i (clr),
    .inc_i (alloc_fire),
    .ptr_o (tail)
  );

  // Allocation and commit never touch the same live entry: when head==tail with
  // both firing, the ROB is either empty (no commit) or full (no allocation).
  always_comb begin
    flags_d = flags_q;
    if (alloc_fire) begin
      flags_d[tail].valid = 1'b1;
      flags_d[tail].done  = 1'b0;
    end
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_hit[i]) flags_d[wb_tag_a[i]].done = 1'b1;
    end
    if (commit_fire) begin
      flags_d[head].valid = 1'b0;
      flags_d[head].done  = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (alloc_fire && !commit_fire)      count_d = count_q + 1'b1;
    else if (commit_fire && !alloc_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) flags_q[i] <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Payload storage carries no reset; stale contents are masked by the flags.
  // Channels are visited in ascending order so the highest index wins a tag clash.
  always_ff @(posedge clk) begin
    if (alloc_fire) reg_q[tail] <= alloc_reg;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_hit[i]) data_q[wb_tag_a[i]] <= wb_data_a[i];
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
module tb_reorder_buffer_mc;

  localparam int DEPTH  = 32;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NUM_WB = 2;
  localparam int TAG_W  = 5;

  logic                     clk;
  logic                     reset;
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [REG_W-1:0]         alloc_reg;
  logic [TAG_W-1:0]         alloc_tag;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic                     commit_valid;
  logic                     commit_ready;
  logic [REG_W-1:0]         commit_reg;
  logic [DATA_W-1:0]        commit_data;
  logic [TAG_W-1:0]         commit_tag;
  logic                     flush;
  logic [TAG_W:0]           count;
  logic                     empty;
  logic                     full;

  int checks;
  int failures;

  reorder_buffer_mc #(
    .DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W), .NUM_WB(NUM_WB)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_reg(alloc_reg), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_reg(commit_reg), .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int tag;
    int rg;
    bit done;
    int unsigned data;
  } ent_t;

  ent_t mq[$];
  int   m_tail;

  task automatic clear_inputs();
    reset = 0; flush = 0; alloc_valid = 0; alloc_reg = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; commit_ready = 0;
  endtask

  task automatic set_wb(input int ch, input int tag, input logic [31:0] d);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*TAG_W +: TAG_W] = TAG_W'(tag);
    wb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_wb();
    wb_valid = '0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic step();
    bit   afire, cfire;
    int   n;
    ent_t e;
    if (reset || flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      n = mq.size();
      afire = alloc_valid && (n < DEPTH);
      cfire = commit_ready && (n > 0) && mq[0].done;
      for (int ch = 0; ch < NUM_WB; ch++) begin
        if (wb_valid[ch]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].tag == int'(wb_tag[ch*TAG_W +: TAG_W])) begin
              e = mq[k];
              e.done = 1'b1;
              e.data = wb_data[ch*DATA_W +: DATA_W];
              mq[k] = e;
            end
          end
        end
      end
      if (cfire) void'(mq.pop_front());
      if (afire) begin
        e.tag = m_tail; e.rg = int'(alloc_reg); e.done = 1'b0; e.data = 0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic alloc_n(input int n, input int reg_base);
    for (int k = 0; k < n; k++) begin
      alloc_valid = 1;
      alloc_reg = REG_W'(reg_base + k);
      step();
    end
    alloc_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      checks++; if (alloc_tag !== 5'(k)) begin failures++; $display("FAIL fill_alloc_tag k=%0d got=%0d exp=%0d", k, alloc_tag, k); end
      alloc_valid = 1; alloc_reg = 5'(k);
      step();
    end
    alloc_valid = 0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_alloc_ready got=%0b exp=0", alloc_ready); end
    checks++; if (count !== 6'd32) begin failures++; $display("FAIL fill_count got=%0d exp=32", count); end
    alloc_valid = 1; alloc_reg = 5'd3;
    step();
    alloc_valid = 0;
    checks++; if (count !== 6'd32) begin failures++; $display("FAIL fill_extra_count got=%0d exp=32", count); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL fill_extra_tag got=%0d exp=0", alloc_tag); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL fill_commit_valid got=%0b exp=0", commit_valid); end
  endtask

  task automatic test_ooo_wb();
    int          exp_t [4] = '{0, 1, 2, 3};
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'hAA, 32'h33};
    do_reset();
    alloc_n(4, 1);
    set_wb(0, 2, 32'hAA); step(); clear_wb();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_early_commit got=%0b exp=0", commit_valid); end
    set_wb(1, 0, 32'h11); step(); clear_wb();
    checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL ooo_commit_rise got=%0b exp=1", commit_valid); end
    set_wb(0, 1, 32'h22); set_wb(1, 3, 32'h33); step(); clear_wb();
    commit_ready = 1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL ooo_valid j=%0d got=%0b exp=1", j, commit_valid); end
      checks++; if (commit_tag !== 5'(exp_t[j])) begin failures++; $display("FAIL ooo_tag j=%0d got=%0d exp=%0d", j, commit_tag, exp_t[j]); end
      checks++; if (commit_data !== exp_d[j]) begin failures++; $display("FAIL ooo_data j=%0d got=%h exp=%h", j, commit_data, exp_d[j]); end
      checks++; if (commit_reg !== 5'(j + 1)) begin failures++; $display("FAIL ooo_reg j=%0d got=%0d exp=%0d", j, commit_reg, j + 1); end
      step();
    end
    commit_ready = 0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ooo_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_same_tag();
    do_reset();
    alloc_n(6, 0);
    set_wb(0, 5, 32'h1); set_wb(1, 5, 32'h2); step(); clear_wb();
    set_wb(0, 9, 32'h99); step(); clear_wb();
    set_wb(0, 0, 32'h100); set_wb(1, 1, 32'h101); step(); clear_wb();
    set_wb(0, 2, 32'h102); set_wb(1, 3, 32'h103); step(); clear_wb();
    set_wb(0, 4, 32'h104); step(); clear_wb();
    commit_ready = 1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL same_valid k=%0d got=%0b exp=1", k, commit_valid); end
      checks++; if (commit_data !== ((k < 5) ? 32'(32'h100 + k) : 32'h2)) begin failures++; $display("FAIL same_data k=%0d got=%h", k, commit_data); end
      step();
    end
    commit_ready = 0;
    alloc_n(4, 6);
    set_wb(0, 6, 32'h206); set_wb(1, 7, 32'h207); step(); clear_wb();
    set_wb(0, 8, 32'h208); step(); clear_wb();
    commit_ready = 1;
    for (int k = 6; k < 9; k++) begin
      checks++; if (commit_tag !== 5'(k)) begin failures++; $display("FAIL same_tag2 got=%0d exp=%0d", commit_tag, k); end
      step();
    end
    commit_ready = 0;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL same_unalloc_wb got=%0b exp=0", commit_valid); end
    checks++; if (commit_tag !== 5'd9) begin failures++; $display("FAIL same_head9 got=%0d exp=9", commit_tag); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL same_count got=%0d exp=1", count); end
  endtask

  task automatic test_steady_wrap();
    logic [31:0] base = 32'hD000_0000;
    do_reset();
    alloc_n(20, 0);
    for (int j = 0; j < 10; j++) begin
      set_wb(0, 2*j, base + 32'(2*j)); set_wb(1, 2*j + 1, base + 32'(2*j + 1));
      step(); clear_wb();
    end
    for (int n = 0; n < 100; n++) begin
      alloc_valid = 1; alloc_reg = 5'(20 + n);
      set_wb(0, (19 + n) % 32, base + 32'(19 + n));
      commit_ready = 1;
      checks++; if (count !== 6'd20) begin failures++; $display("FAIL wrap_count n=%0d got=%0d exp=20", n, count); end
      checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid n=%0d got=%0b exp=1", n, commit_valid); end
      checks++; if (commit_tag !== 5'(n % 32)) begin failures++; $display("FAIL wrap_tag n=%0d got=%0d exp=%0d", n, commit_tag, n % 32); end
      checks++; if (commit_data !== base + 32'(n)) begin failures++; $display("FAIL wrap_data n=%0d got=%h exp=%h", n, commit_data, base + 32'(n)); end
      checks++; if (commit_reg !== 5'(n % 32)) begin failures++; $display("FAIL wrap_reg n=%0d got=%0d exp=%0d", n, commit_reg, n % 32); end
      checks++; if (alloc_tag !== 5'((20 + n) % 32)) begin failures++; $display("FAIL wrap_alloc_tag n=%0d got=%0d exp=%0d", n, alloc_tag, (20 + n) % 32); end
      step();
    end
    clear_inputs();
    checks++; if (count !== 6'd20) begin failures++; $display("FAIL wrap_final_count got=%0d exp=20", count); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(10, 0);
    set_wb(0, 0, 32'h10); set_wb(1, 1, 32'h11); step(); clear_wb();
    set_wb(0, 2, 32'h12); set_wb(1, 3, 32'h13); step(); clear_wb();
    checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%0b exp=1", commit_valid); end
    flush = 1; alloc_valid = 1; alloc_reg = 5'd3; commit_ready = 1; set_wb(0, 5, 32'h55);
    step();
    clear_inputs();
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b exp=1", empty); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL flush_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL flush_commit_valid got=%0b exp=0", commit_valid); end
    alloc_n(1, 7);
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_done got=%0b exp=0", commit_valid); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL flush_realloc_count got=%0d exp=1", count); end
  endtask

  task automatic test_full_commit();
    do_reset();
    alloc_n(32, 0);
    set_wb(0, 0, 32'h5A); step(); clear_wb();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fc_full got=%0b exp=1", full); end
    checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL fc_valid got=%0b exp=1", commit_valid); end
    checks++; if (commit_data !== 32'h5A) begin failures++; $display("FAIL fc_data got=%h exp=5a", commit_data); end
    alloc_valid = 1; alloc_reg = 5'd7; commit_ready = 1;
    step();
    clear_inputs();
    checks++; if (count !== 6'd31) begin failures++; $display("FAIL fc_count got=%0d exp=31", count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL fc_full_after got=%0b exp=0", full); end
    checks++; if (alloc_tag !== 5'd0) begin failures++; $display("FAIL fc_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (commit_tag !== 5'd1) begin failures++; $display("FAIL fc_head got=%0d exp=1", commit_tag); end
    alloc_n(1, 9);
    checks++; if (count !== 6'd32) begin failures++; $display("FAIL fc_refill_count got=%0d exp=32", count); end
    checks++; if (alloc_tag !== 5'd1) begin failures++; $display("FAIL fc_refill_tag got=%0d exp=1", alloc_tag); end
  endtask

  task automatic test_random();
    bit exp_cv;
    int n;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n = mq.size();
      exp_cv = (n > 0) && mq[0].done;
      checks++; if (count !== 6'(n)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, n); end
      checks++; if (full !== (n == DEPTH)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%0b exp=%0b", cyc, full, n == DEPTH); end
      checks++; if (empty !== (n == 0)) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%0b exp=%0b", cyc, empty, n == 0); end
      checks++; if (alloc_ready !== (n != DEPTH)) begin failures++; $display("FAIL rnd_alloc_ready cyc=%0d got=%0b", cyc, alloc_ready); end
      checks++; if (alloc_tag !== 5'(m_tail)) begin failures++; $display("FAIL rnd_alloc_tag cyc=%0d got=%0d exp=%0d", cyc, alloc_tag, m_tail); end
      checks++; if (commit_valid !== exp_cv) begin failures++; $display("FAIL rnd_commit_valid cyc=%0d got=%0b exp=%0b", cyc, commit_valid, exp_cv); end
      if (exp_cv) begin
        checks++; if (commit_tag !== 5'(mq[0].tag)) begin failures++; $display("FAIL rnd_commit_tag cyc=%0d got=%0d exp=%0d", cyc, commit_tag, mq[0].tag); end
        checks++; if (commit_reg !== 5'(mq[0].rg)) begin failures++; $display("FAIL rnd_commit_reg cyc=%0d got=%0d exp=%0d", cyc, commit_reg, mq[0].rg); end
        checks++; if (commit_data !== mq[0].data) begin failures++; $display("FAIL rnd_commit_data cyc=%0d got=%h exp=%h", cyc, commit_data, mq[0].data); end
      end
      alloc_valid  = ($urandom_range(0, 2) != 0);
      alloc_reg    = REG_W'($urandom);
      commit_ready = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 99) == 0);
      wb_valid     = '0;
      for (int ch = 0; ch < NUM_WB; ch++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (n > 0 && $urandom_range(0, 3) != 0) set_wb(ch, mq[$urandom_range(0, n - 1)].tag, $urandom);
          else set_wb(ch, $urandom_range(0, DEPTH - 1), $urandom);
        end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_tail = 0;
    clear_inputs();
    test_reset();
    test_fill();
    test_ooo_wb();
    test_same_tag();
    test_steady_wrap();
    test_flush();
    test_full_commit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
